count_spi_sender: RTL and testbench

COUNT_SPI_SENDER -- requirements
Module: count_spi_sender

---
 rtl/count_spi_sender_pkg.sv | 17 +
 rtl/count_spi_sender.sv | 96 +++++++++
 tb/tb_count_spi_sender.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_spi_sender_pkg.sv
// Shared widths, marker default and FSM state type for the count-to-SPI frame sender.
package count_spi_sender_pkg;

  localparam int unsigned COUNT_W = 14;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [1:0] MARKER_DEFAULT = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    WAIT_HI,
    LOAD_LO,
    WAIT_LO
  } state_t;

endpackage

// File: rtl/count_spi_sender.sv
// Sends a 14-bit count to an SPI master as two bytes: {MARKER, count[13:8]} then count[7:0].
// A frame is launched on a count change (AUTO_SEND) or on i_send, one byte per o_start/i_done handshake.
module count_spi_sender
  import count_spi_sender_pkg::*;
#(
  parameter logic [1:0]  MARKER    = MARKER_DEFAULT,
  parameter int unsigned AUTO_SEND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COUNT_W-1:0]   i_count,
  input  logic                 i_send,
  input  logic                 i_ready,
  input  logic                 i_done,
  output logic                 o_start,
  output logic [BYTE_W-1:0]    o_tx_data,
  output logic                 o_busy,
  output logic [BYTE_W-1:0]    o_frame_cnt
);

  state_t               state, state_nxt;
  logic [COUNT_W-1:0]   snap, snap_nxt;
  logic [COUNT_W-1:0]   last_sent, last_nxt;
  logic                 start_nxt;
  logic [BYTE_W-1:0]    tx_nxt;
  logic [BYTE_W-1:0]    cnt_nxt;
  logic                 trigger;

  assign trigger = ((AUTO_SEND != 0) && (i_count != last_sent)) || i_send;
  assign o_busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      snap        <= '0;
      last_sent   <= '1;
      o_start     <= 1'b0;
      o_tx_data   <= '0;
      o_frame_cnt <= '0;
    end else begin
      state       <= state_nxt;
      snap        <= snap_nxt;
      last_sent   <= last_nxt;
      o_start     <= start_nxt;
      o_tx_data   <= tx_nxt;
      o_frame_cnt <= cnt_nxt;
    end
  end

  // o_start is registered, so the pulse appears the cycle the FSM enters WAIT_x;
  // the high byte is loaded with the snapshot so it is already stable in LOAD_HI.
  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    last_nxt  = last_sent;
    start_nxt = 1'b0;
    tx_nxt    = o_tx_data;
    cnt_nxt   = o_frame_cnt;
    case (state)
      IDLE: begin
        if (trigger) begin
          snap_nxt  = i_count;
          tx_nxt    = {MARKER, i_count[COUNT_W-1:BYTE_W]};
          state_nxt = LOAD_HI;
        end
      end
      LOAD_HI: begin
        if (i_ready) begin
          start_nxt = 1'b1;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (i_done) begin
          tx_nxt    = snap[BYTE_W-1:0];
          state_nxt = LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (i_ready) begin
          start_nxt = 1'b1;
          state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (i_done) begin
          last_nxt  = snap;
          cnt_nxt   = o_frame_cnt + 8'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_count_spi_sender.sv
// Randomised scoreboard bench for count_spi_sender plus a directed check of the AUTO_SEND=0 variant.
module tb_count_spi_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;

  // Instance A: AUTO_SEND = 1
  logic [13:0] cnt_a = '0;
  logic        send_a = 1'b0, ready_a = 1'b1;
  logic        resp_done = 1'b0, stray_done = 1'b0, done_a;
  logic        start_a, busy_a;
  logic [7:0]  tx_a, fc_a;
  assign done_a = resp_done | stray_done;

  // Instance B: AUTO_SEND = 0
  logic [13:0] cnt_b = '0;
  logic        send_b = 1'b0, ready_b = 1'b1, done_b = 1'b0;
  logic        start_b, busy_b;
  logic [7:0]  tx_b, fc_b;

  count_spi_sender #(.MARKER(2'b10), .AUTO_SEND(1)) dut_a (
    .clk(clk), .rst(rst), .i_count(cnt_a), .i_send(send_a), .i_ready(ready_a),
    .i_done(done_a), .o_start(start_a), .o_tx_data(tx_a), .o_busy(busy_a),
    .o_frame_cnt(fc_a)
  );

  count_spi_sender #(.MARKER(2'b10), .AUTO_SEND(0)) dut_b (
    .clk(clk), .rst(rst), .i_count(cnt_b), .i_send(send_b), .i_ready(ready_b),
    .i_done(done_b), .o_start(start_b), .o_tx_data(tx_b), .o_busy(busy_b),
    .o_frame_cnt(fc_b)
  );

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int unsigned hi_of(input int unsigned c);
    return 2 * 64 + c / 256;
  endfunction

  function automatic int unsigned lo_of(input int unsigned c);
    return c % 256;
  endfunction

  // Behavioural reference: a sender is either idle or carrying one snapshot;
  // when idle it starts a frame if the count differs from the last one delivered or send is asked.
  bit          mbusy = 1'b0;
  bit          want_ready = 1'b0;
  bit          exp_start = 1'b0;
  int unsigned mlast = 16383, msnap = 0, mframes = 0, mndone = 0;
  int unsigned byte_q[$];

  always @(posedge clk) begin
    if (rst) begin
      mbusy = 1'b0; want_ready = 1'b0; exp_start = 1'b0;
      mlast = 16383; msnap = 0; mframes = 0; mndone = 0;
      byte_q.delete();
    end else begin
      exp_start = 1'b0;
      if (want_ready && ready_a) begin
        exp_start  = 1'b1;
        want_ready = 1'b0;
      end
      if (mbusy) begin
        if (resp_done) begin
          mndone++;
          if (mndone == 1) want_ready = 1'b1;
          else begin
            mbusy   = 1'b0;
            mlast   = msnap;
            mframes = (mframes + 1) % 256;
          end
        end
      end else if ((cnt_a != mlast) || send_a) begin
        mbusy = 1'b1;
        msnap = cnt_a;
        mndone = 0;
        want_ready = 1'b1;
        byte_q.push_back(hi_of(msnap));
        byte_q.push_back(lo_of(msnap));
      end
    end
  end

  // SPI slave model for A: answers each o_start with i_done after dly cycles.
  int unsigned dly = 3;
  int unsigned cd = 0;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      cd = 0;
      resp_done = 1'b0;
    end else begin
      resp_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) resp_done = 1'b1;
      end
      if (start_a) cd = dly;
    end
  end

  // Monitor for A, sampled mid-cycle.
  bit          inflight = 1'b0;
  int unsigned cur_byte = 0;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_start", start_a, 0);
      check("rst_tx", tx_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_frame_cnt", fc_a, 0);
      inflight = 1'b0;
    end else begin
      check("start", start_a, exp_start);
      check("busy", busy_a, mbusy);
      check("frame_cnt", fc_a, mframes);
      if (start_a) begin
        check("start_has_byte", byte_q.size() > 0, 1);
        if (byte_q.size() > 0) cur_byte = byte_q.pop_front();
        inflight = 1'b1;
      end
      if (inflight) check("tx_data", tx_a, cur_byte);
      if (inflight && resp_done) inflight = 1'b0;
    end
  end

  int unsigned b_starts = 0;
  always @(negedge clk) if (!rst && start_b) b_starts++;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (!mbusy && !inflight && byte_q.size() == 0 && cnt_a == mlast && !send_a) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned f0;
    bit ok;
    tick(3);
    rst = 1'b0;

    // first value after reset (0) must be sent
    wait_idle();
    check("first_frame_cnt", fc_a, 1);

    // 1234 with slow slave
    dly = 10;
    cnt_a = 14'd1234;
    wait_idle();
    check("frame_cnt_1234", fc_a, 2);

    // coalescing of changes during a frame
    dly = 4;
    cnt_a = 14'd5;
    f0 = fc_a;
    tick(2);
    cnt_a = 14'd6;
    tick(3);
    cnt_a = 14'd7;
    wait_idle();
    check("coalesce_frames", (fc_a - f0) % 256, 2);

    // i_ready held low while loading the high byte
    ready_a = 1'b0;
    cnt_a = 14'd100;
    tick(20);
    check("no_start_while_not_ready", busy_a, 1);
    ready_a = 1'b1;
    wait_idle();

    // randomised traffic, including values above 9999 and stray i_done
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) cnt_a = 14'($urandom_range(0, 16383));
      send_a  = ($urandom_range(0, 15) == 0);
      ready_a = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) dly = $urandom_range(1, 12);
      stray_done = !mbusy && ($urandom_range(0, 9) == 0);
      tick(1);
    end
    send_a = 1'b0; stray_done = 1'b0; ready_a = 1'b1;
    wait_idle();

    // reset while the low byte is in flight
    dly = 8;
    cnt_a = 14'd4321;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (mndone == 1 && inflight) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_wait_lo", ok, 1);
    rst = 1'b1;
    tick(1);
    check("abort_frame_cnt", fc_a, 0);
    check("abort_busy", busy_a, 0);
    tick(1);
    rst = 1'b0;
    wait_idle();
    check("post_reset_frame_cnt", fc_a, 1);

    // frame counter wrap
    dly = 1;
    for (int k = 0; k < 256; k++) begin
      cnt_a = 14'((cnt_a + 1) % 16384);
      wait_idle();
    end
    check("frame_cnt_wrap", fc_a, 1);

    // AUTO_SEND=0 instance: no frame on count change, i_send only, late i_send dropped
    cnt_b = 14'd9999;
    tick(5);
    check("b_no_auto", b_starts, 0);
    check("b_idle", busy_b, 0);
    send_b = 1'b1;
    tick(1);
    send_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (b_starts == 1) begin ok = 1'b1; break; end
    end
    check("b_start_hi", ok, 1);
    check("b_byte_hi", tx_b, hi_of(9999));
    tick(3);
    check("b_hold_hi", tx_b, hi_of(9999));
    done_b = 1'b1;
    tick(1);
    done_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (b_starts == 2) begin ok = 1'b1; break; end
    end
    check("b_start_lo", ok, 1);
    check("b_byte_lo", tx_b, lo_of(9999));
    send_b = 1'b1;
    tick(1);
    send_b = 1'b0;
    tick(2);
    done_b = 1'b1;
    tick(1);
    done_b = 1'b0;
    tick(1);
    check("b_busy_drop", busy_b, 0);
    tick(10);
    check("b_total_starts", b_starts, 2);
    check("b_frame_cnt", fc_b, 1);
    done_b = 1'b1;
    tick(1);
    done_b = 1'b0;
    tick(5);
    check("b_stray_done", b_starts, 2);

    check("queue_empty", byte_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
